regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Shares the register-file write port between the ALU (strict
//            priority, never stalled) and load writebacks buffered in a small
//            FIFO. Exports per-source-register pending flags for decode.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  // ALU writeback, no backpressure
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  // Load writeback, valid/ready handshake
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  // Register file write port (registered)
  output logic        w_enabled,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  // Decode hazard query
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_pending,
  output logic        rs2_pending
);

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // FIFO storage and bookkeeping
  logic [4:0]       fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [DEPTH-1:0] fifo_live_q;
  logic [DEPTH-1:0] fifo_live_d;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] head_d;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] tail_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Write port registers
  logic             w_en_q;
  logic             w_en_d;
  logic [4:0]       w_addr_q;
  logic [4:0]       w_addr_d;
  logic [31:0]      w_data_q;
  logic [31:0]      w_data_d;

  // Per-cycle control decisions
  logic             alu_wr;
  logic             mem_accept;
  logic             push;
  logic             pop;

  // Occupancy / hazard match masks
  logic [DEPTH-1:0] occ_mask;
  logic [DEPTH-1:0] rs1_match;
  logic [DEPTH-1:0] rs2_match;

  assign mem_ready = (count_q != FULL_COUNT);

  // Handshake and slot arbitration: ALU owns the slot whenever it is valid,
  // even for x0, so the FIFO only drains in ALU-idle cycles.
  always_comb begin
    alu_wr     = alu_valid && (alu_addr != 5'd0);
    mem_accept = mem_valid && mem_ready;
    push       = mem_accept && (mem_addr != 5'd0);
    pop        = !alu_valid && (count_q != '0);
  end

  // Live-bit update: ALU kills older same-address loads; a load pushed in the
  // same cycle is younger than the ALU write, so the push is applied last.
  always_comb begin
    fifo_live_d = fifo_live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_wr && (fifo_addr_q[i] == alu_addr)) begin
        fifo_live_d[i] = 1'b0;
      end
    end
    // Head and tail only coincide when empty (no pop) or full (no push).
    if (pop) begin
      fifo_live_d[head_q] = 1'b0;
    end
    if (push) begin
      fifo_live_d[tail_q] = 1'b1;
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Write slot selection; address/data hold when nothing is written
  always_comb begin
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (alu_valid) begin
      if (alu_addr != 5'd0) begin
        w_en_d   = 1'b1;
        w_addr_d = alu_addr;
        w_data_d = alu_data;
      end
    end else if (count_q != '0) begin
      if (fifo_live_q[head_q]) begin
        w_en_d   = 1'b1;
        w_addr_d = fifo_addr_q[head_q];
        w_data_d = fifo_data_q[head_q];
      end
    end
  end

  // Hazard detection over occupied, live entries (registered state only)
  always_comb begin
    occ_mask  = '0;
    rs1_match = '0;
    rs2_match = '0;
    for (int p = 0; p < DEPTH; p++) begin
      // Distance from head, modulo DEPTH, tells whether slot p is occupied.
      occ_mask[p]  = ({1'b0, PTR_W'(p) - head_q} < count_q);
      rs1_match[p] = occ_mask[p] && fifo_live_q[p] && (fifo_addr_q[p] == rs1_addr);
      rs2_match[p] = occ_mask[p] && fifo_live_q[p] && (fifo_addr_q[p] == rs2_addr);
    end
  end

  assign rs1_pending = (rs1_addr != 5'd0) && (|rs1_match);
  assign rs2_pending = (rs2_addr != 5'd0) && (|rs2_match);

  // FIFO state registers; reset discards every queued load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fifo_live_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= 5'd0;
        fifo_data_q[i] <= 32'd0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fifo_live_q <= fifo_live_d;
      if (push) begin
        fifo_addr_q[tail_q] <= mem_addr;
        fifo_data_q[tail_q] <= mem_data;
      end
    end
  end

  // Register-file write port registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_en_q   <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
    end else begin
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign w_enabled = w_en_q;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed bench for regfile_wb_arbiter. Expected register-file
//            writes are queued in issue order; a negedge monitor pops and
//            compares every write the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rstn;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        w_enabled;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_pending;
  logic        rs2_pending;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .w_enabled  (w_enabled),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_pending(rs1_pending),
    .rs2_pending(rs2_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid = v;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
    mem_valid = v;
    mem_addr  = a;
    mem_data  = d;
  endtask

  // Scoreboard monitor: every presented write must match the oldest expectation
  wr_t mon_e;
  always @(negedge clk) begin
    if (rstn && w_enabled) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got x%0d=%h, expected no write", w_addr, w_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (w_addr === mon_e.a && w_data === mon_e.d) n_pass++;
        else $display("FAIL write_order: got x%0d=%h, expected x%0d=%h",
                      w_addr, w_data, mon_e.a, mon_e.d);
      end
    end
  end

  // Watchdog bound on the whole run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    step();
    step();
    chk("reset_w_enabled", w_enabled, 1'b0);
    chk("reset_w_addr",    w_addr,    5'd0);
    chk("reset_w_data",    w_data,    32'd0);
    chk("reset_mem_ready", mem_ready, 1'b1);
    rstn = 1'b1;
    step();

    // ALU write, then ALU to x0 consumes the slot without writing
    expect_wr(5'd5, 32'h11);
    set_alu(1'b1, 5'd5, 32'h11);
    step();
    chk("alu_w_enabled", w_enabled, 1'b1);
    chk("alu_w_addr",    w_addr,    5'd5);
    chk("alu_w_data",    w_data,    32'h11);
    set_alu(1'b1, 5'd0, 32'h99);
    step();
    chk("alu_x0_no_write", w_enabled, 1'b0);

    // Loads queue up behind a busy ALU, then drain in order
    expect_wr(5'd1, 32'h101);
    expect_wr(5'd2, 32'h102);
    expect_wr(5'd3, 32'h103);
    expect_wr(5'd8, 32'h108);
    expect_wr(5'd6, 32'hA);
    expect_wr(5'd7, 32'hB);
    set_alu(1'b1, 5'd1, 32'h101);
    set_mem(1'b1, 5'd6, 32'hA);
    step();
    set_alu(1'b1, 5'd2, 32'h102);
    set_mem(1'b1, 5'd7, 32'hB);
    step();
    chk("full_mem_ready", mem_ready, 1'b0);
    rs1_addr = 5'd6;
    rs2_addr = 5'd7;
    #1;
    chk("pend_rs1_x6", rs1_pending, 1'b1);
    chk("pend_rs2_x7", rs2_pending, 1'b1);
    set_alu(1'b1, 5'd3, 32'h103);
    set_mem(1'b0, 5'd0, 32'd0);
    step();
    set_alu(1'b1, 5'd8, 32'h108);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    step();
    chk("drain1_mem_ready", mem_ready, 1'b1);
    chk("drain1_rs1_clear", rs1_pending, 1'b0);
    chk("drain1_rs2_held",  rs2_pending, 1'b1);
    step();
    chk("drain2_rs2_clear", rs2_pending, 1'b0);

    // Kill: ALU write to x9 supersedes an older queued load to x9
    expect_wr(5'd9, 32'h77);
    set_mem(1'b1, 5'd9, 32'h55);
    step();
    set_mem(1'b0, 5'd0, 32'd0);
    rs1_addr = 5'd9;
    #1;
    chk("kill_pend_before", rs1_pending, 1'b1);
    set_alu(1'b1, 5'd9, 32'h77);
    step();
    chk("kill_pend_after", rs1_pending, 1'b0);
    set_alu(1'b0, 5'd0, 32'd0);
    step();
    chk("kill_pop_no_write", w_enabled, 1'b0);
    chk("kill_mem_ready",    mem_ready, 1'b1);

    // Same-cycle ALU and load to x4: the load is younger and survives
    expect_wr(5'd4, 32'h1);
    expect_wr(5'd4, 32'h2);
    set_alu(1'b1, 5'd4, 32'h1);
    set_mem(1'b1, 5'd4, 32'h2);
    step();
    rs1_addr = 5'd4;
    #1;
    chk("same_cycle_pend", rs1_pending, 1'b1);
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    step();
    chk("same_cycle_pend_clr", rs1_pending, 1'b0);

    // Load to x0 is accepted but never enqueued
    expect_wr(5'd10, 32'h10);
    expect_wr(5'd12, 32'h12);
    expect_wr(5'd13, 32'h13);
    expect_wr(5'd11, 32'h1111);
    expect_wr(5'd14, 32'h1414);
    set_alu(1'b1, 5'd10, 32'h10);
    set_mem(1'b1, 5'd11, 32'h1111);
    step();
    set_alu(1'b1, 5'd12, 32'h12);
    set_mem(1'b1, 5'd0, 32'hDEAD);
    step();
    chk("x0_count_unchanged", mem_ready, 1'b1);
    set_alu(1'b1, 5'd13, 32'h13);
    set_mem(1'b1, 5'd14, 32'h1414);
    step();
    chk("x0_then_full", mem_ready, 1'b0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    step();
    step();
    step();
    chk("x0_idle_no_write", w_enabled, 1'b0);

    // Reset with two queued loads discards them
    expect_wr(5'd15, 32'h15);
    expect_wr(5'd17, 32'h17);
    set_alu(1'b1, 5'd15, 32'h15);
    set_mem(1'b1, 5'd16, 32'h16);
    step();
    set_alu(1'b1, 5'd17, 32'h17);
    set_mem(1'b1, 5'd18, 32'h18);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    rs1_addr = 5'd16;
    chk("prereset_full", mem_ready, 1'b0);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_w_enabled", w_enabled, 1'b0);
    chk("rst_w_addr",    w_addr,    5'd0);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_pending",   rs1_pending, 1'b0);
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("post_reset_no_write", w_enabled, 1'b0);

    // Full FIFO with idle ALU: pop without push, then wrap over 10 pushes
    expect_wr(5'd1, 32'h201);
    expect_wr(5'd2, 32'h202);
    expect_wr(5'd20, 32'hA0);
    expect_wr(5'd21, 32'hA1);
    set_alu(1'b1, 5'd1, 32'h201);
    set_mem(1'b1, 5'd20, 32'hA0);
    step();
    set_alu(1'b1, 5'd2, 32'h202);
    set_mem(1'b1, 5'd21, 32'hA1);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b1, 5'd22, 32'hA2);
    chk("stall_full", mem_ready, 1'b0);
    step();
    chk("stall_pop_only", mem_ready, 1'b1);
    for (int k = 2; k < 10; k++) begin
      logic acc;
      acc = 1'b0;
      set_mem(1'b1, 5'(20 + k), 32'(32'hA0 + k));
      for (int g = 0; g < 8 && !acc; g++) begin
        acc = mem_ready;
        step();
      end
      chk("wrap_push_accept", acc, 1'b1);
      expect_wr(5'(20 + k), 32'(32'hA0 + k));
    end
    set_mem(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
